// File: rtl/vrf_read_port_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vrf_read_sched_pkg
// Shared definitions for the VRF read port scheduler: default widths, the
// in-flight read tag carried through the latency pipeline, and the
// round-robin successor helper used by the arbiter.
// -----------------------------------------------------------------------------
package vrf_read_sched_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int VS_W_DEF     = 5;
  localparam int OFFSET_W_DEF = 9;
  localparam int IDX_W_DEF    = 3;
  localparam int DATA_W_DEF   = 32;

  // Tag fields are sized for the largest supported configuration.
  // Narrower source/index values are zero-extended into them.
  localparam int TAG_SRC_W = 8;
  localparam int TAG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_SRC_W-1:0] source;
    logic [TAG_IDX_W-1:0] instructionIndex;
  } read_tag_t;

  // Next requester after 'cur' in a ring of 'n' requesters.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/vrf_read_port_scheduler_if.sv
// -----------------------------------------------------------------------------
// vrf_read_port_scheduler_if
// Bundles the requester side, the VRF bank side, the kill/write-busy controls
// and the response bus of the read port scheduler.
//   slave  : the scheduler (consumes requests, drives ready/issue/response)
//   master : the environment (requesters, bank, pipeline control)
// -----------------------------------------------------------------------------
interface vrf_read_port_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int VS_W     = 5,
  parameter int OFFSET_W = 9,
  parameter int IDX_W    = 3,
  parameter int DATA_W   = 32,
  parameter int SRC_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*VS_W-1:0]     req_vs;
  logic [NUM_REQ*OFFSET_W-1:0] req_offset;
  logic [NUM_REQ*IDX_W-1:0]    req_instructionIndex;
  logic                        write_busy;
  logic                        kill_valid;
  logic [IDX_W-1:0]            kill_instructionIndex;
  logic                        vrf_read_valid;
  logic [VS_W-1:0]             vrf_read_vs;
  logic [OFFSET_W-1:0]         vrf_read_offset;
  logic [DATA_W-1:0]           vrf_read_data;
  logic                        resp_valid;
  logic [SRC_W-1:0]            resp_source;
  logic [IDX_W-1:0]            resp_instructionIndex;
  logic [DATA_W-1:0]           resp_data;

  modport slave (
    input  req_valid, req_vs, req_offset, req_instructionIndex,
    input  write_busy, kill_valid, kill_instructionIndex, vrf_read_data,
    output req_ready, vrf_read_valid, vrf_read_vs, vrf_read_offset,
    output resp_valid, resp_source, resp_instructionIndex, resp_data
  );

  modport master (
    output req_valid, req_vs, req_offset, req_instructionIndex,
    output write_busy, kill_valid, kill_instructionIndex, vrf_read_data,
    input  req_ready, vrf_read_valid, vrf_read_vs, vrf_read_offset,
    input  resp_valid, resp_source, resp_instructionIndex, resp_data
  );

endinterface

// File: rtl/vrf_read_port_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vrf_read_sched_rr_arbiter
// Round-robin grant over NUM_REQ eligible lines, with the 'last granted'
// pointer held here.
//   clock, reset      : clock and synchronous active-high reset
//   enable_i          : arbitration allowed this cycle
//   eligible_i        : per-requester eligibility
//   grant_o           : one-hot or zero grant (combinational)
//   grantValid_o      : some requester was granted
//   grantIdx_o        : index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module vrf_read_sched_rr_arbiter
  import vrf_read_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [NUM_REQ-1:0] eligible_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grantValid_o,
  output logic [SRC_W-1:0]   grantIdx_o
);

  logic [SRC_W-1:0] last_q, last_d;

  // Walk the ring starting just after the last winner; the first eligible
  // requester met takes the grant.
  always_comb begin
    int  cand;
    logic found;
    grant_o      = '0;
    grantValid_o = 1'b0;
    grantIdx_o   = '0;
    found        = 1'b0;
    cand         = int'(last_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_next(cand, NUM_REQ);
      if (!found && enable_i && eligible_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grantIdx_o    = SRC_W'(cand);
      end
    end
    grantValid_o = found;
  end

  // Pointer only moves on a grant.
  always_comb begin
    last_d = grantValid_o ? grantIdx_o : last_q;
  end

  // Reset points at the last requester so requester 0 leads afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= SRC_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vrf_read_port_scheduler.sv
// -----------------------------------------------------------------------------
// vrf_read_port_scheduler
// Shares one VRF read port among NUM_REQ requesters round-robin, tracks each
// issued read through a READ_LATENCY-deep tag pipeline and returns the bank
// data tagged with its requester on a common response bus.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : requests/ready, write_busy, kill, VRF issue, bank data,
//                  response bus
// -----------------------------------------------------------------------------
module vrf_read_port_scheduler
  import vrf_read_sched_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int READ_LATENCY = 2,
  parameter int VS_W         = VS_W_DEF,
  parameter int OFFSET_W     = OFFSET_W_DEF,
  parameter int IDX_W        = IDX_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SRC_W        = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  vrf_read_port_scheduler_if.slave bus
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grantValid;
  logic [SRC_W-1:0]   grantIdx;
  logic [IDX_W-1:0]   winnerIdx;
  read_tag_t          issueTag;
  read_tag_t          tag_q [READ_LATENCY];
  read_tag_t          tag_d [READ_LATENCY];
  read_tag_t          finalTag;

  function automatic logic killHit(input read_tag_t t, input logic kv,
                                   input logic [IDX_W-1:0] kIdx);
    return kv && (t.instructionIndex == TAG_IDX_W'(kIdx));
  endfunction

  // A requester whose instruction is being flushed this cycle is not eligible,
  // so a killed request is never issued.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] &&
                    !(bus.kill_valid &&
                      (bus.req_instructionIndex[i*IDX_W +: IDX_W] ==
                       bus.kill_instructionIndex));
    end
  end

  vrf_read_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_arbiter (
    .clock        (clock),
    .reset        (reset),
    .enable_i     (!reset && !bus.write_busy),
    .eligible_i   (eligible),
    .grant_o      (grant),
    .grantValid_o (grantValid),
    .grantIdx_o   (grantIdx)
  );

  // The grant is one-hot, so OR-ing the masked fields selects the winner and
  // yields zero on the issue bus when nothing is granted.
  always_comb begin
    bus.req_ready       = grant;
    bus.vrf_read_valid  = grantValid;
    bus.vrf_read_vs     = '0;
    bus.vrf_read_offset = '0;
    winnerIdx           = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        bus.vrf_read_vs     = bus.vrf_read_vs | bus.req_vs[i*VS_W +: VS_W];
        bus.vrf_read_offset = bus.vrf_read_offset |
                              bus.req_offset[i*OFFSET_W +: OFFSET_W];
        winnerIdx           = winnerIdx |
                              bus.req_instructionIndex[i*IDX_W +: IDX_W];
      end
    end
  end

  // Next state of the tag pipeline: stage 0 takes the issue tag, the rest
  // shift forward, and any tag of the flushed instruction loses its valid
  // on the way.
  always_comb begin
    issueTag.valid            = grantValid;
    issueTag.source           = TAG_SRC_W'(grantIdx);
    issueTag.instructionIndex = TAG_IDX_W'(winnerIdx);
    tag_d[0] = issueTag;
    if (killHit(issueTag, bus.kill_valid, bus.kill_instructionIndex)) begin
      tag_d[0].valid = 1'b0;
    end
    for (int s = 1; s < READ_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
      if (killHit(tag_q[s-1], bus.kill_valid, bus.kill_instructionIndex)) begin
        tag_d[s].valid = 1'b0;
      end
    end
  end

  // Reset drops every in-flight read so nothing issued earlier responds.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  // The last stage drives the response; a kill arriving in the response
  // cycle itself still suppresses it.
  always_comb begin
    finalTag                  = tag_q[READ_LATENCY-1];
    bus.resp_valid            = finalTag.valid && !reset &&
                                !killHit(finalTag, bus.kill_valid,
                                         bus.kill_instructionIndex);
    bus.resp_source           = '0;
    bus.resp_instructionIndex = '0;
    bus.resp_data             = '0;
    if (bus.resp_valid) begin
      bus.resp_source           = SRC_W'(finalTag.source);
      bus.resp_instructionIndex = IDX_W'(finalTag.instructionIndex);
      bus.resp_data             = bus.vrf_read_data;
    end
  end

endmodule

// File: doc/vrf_read_port_scheduler.md
# vrf_read_port_scheduler

Shares one vector register file read port among `NUM_REQ` read-stage requesters using round-robin arbitration. It issues the winning request to the VRF bank and tracks each in-flight read through a fixed-latency tag pipeline. It then routes the returned data, tagged with its source, back on a common response bus. It sits between the lane's read-stage request queues and the VRF bank, below the per-slot read arbiters.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `READ_LATENCY`, default 2: cycles from VRF issue to `vrf_read_data` valid, at least 1.
- `VS_W`, default 5: register index width.
- `OFFSET_W`, default 9: offset width.
- `IDX_W`, default 3: instructionIndex width.
- `DATA_W`, default 32: read data width.
- `SRC_W`, default clog2(`NUM_REQ`): response source tag width.

Ports:
- `clock`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester grant / handshake.
- `req_vs`  in  NUM_REQ*VS_W  packed register indices.
- `req_offset`  in  NUM_REQ*OFFSET_W  packed offsets.
- `req_instructionIndex`  in  NUM_REQ*IDX_W  packed owning instruction.
- `write_busy`  in  1  VRF write uses the bank this cycle; no read issue.
- `kill_valid`  in  1  flush reads of one instruction.
- `kill_instructionIndex`  in  IDX_W  instruction to flush.
- `vrf_read_valid`  out  1  read issued to bank this cycle.
- `vrf_read_vs`  out  VS_W  register index of the issued read.
- `vrf_read_offset`  out  OFFSET_W  offset of the issued read.
- `vrf_read_data`  in  DATA_W  bank data, READ_LATENCY cycles after issue.
- `resp_valid`  out  1  response valid; no backpressure.
- `resp_source`  out  SRC_W  requester index of the response.
- `resp_instructionIndex`  out  IDX_W  instruction of the response.
- `resp_data`  out  DATA_W  read data.

## Operation
- Eligible requester i: `req_valid[i]` is high, and not (`kill_valid` with `req_instructionIndex[i] == kill_instructionIndex`).
- Arbitration is disabled while `write_busy` is high: all `req_ready` are 0 and `vrf_read_valid` is 0.
- Round-robin with pointer `last` (the last granted index). Priority order is `last+1`, `last+2`, … modulo NUM_REQ. The first eligible requester in that order wins.
- `req_ready` is one-hot or zero and is combinational from the inputs and `last`. `req_ready[i]` never depends on `req_valid[i]` alone; it requires eligibility.
- Handshake on requester i means `req_ready[i]` is high. On that cycle:
  - `vrf_read_valid` is 1.
  - `vrf_read_vs` and `vrf_read_offset` take the winner's fields.
  - `last` becomes i at the next edge.
- With no grant, `last` holds. When `vrf_read_valid` is 0, `vrf_read_vs` and `vrf_read_offset` are 0.
- Tag pipeline: READ_LATENCY stages, each holding {valid, source, instructionIndex}.
  - Stage 0 loads the issue tag at the issue edge.
  - Each stage shifts forward every cycle.
- Kill: while `kill_valid` is high, every stage whose instructionIndex matches has its valid cleared as it shifts. This includes the tag being loaded that cycle, although a matching request is never granted anyway.
- Response: `resp_valid` equals the valid bit of the final stage. `resp_source` and `resp_instructionIndex` come from that stage, and `resp_data` equals `vrf_read_data`.
  - Kill also applies combinationally to the final stage: if `kill_valid` matches that stage, `resp_valid` is 0 that cycle.
- When `resp_valid` is 0, `resp_source`, `resp_instructionIndex` and `resp_data` are 0.

## Timing
- Reset values:
  - `last` = NUM_REQ-1, so requester 0 has first priority.
  - All tag valids are 0.
  - `resp_valid`, `resp_source`, `resp_instructionIndex` and `resp_data` are 0.
  - `req_ready` and `vrf_read_valid` are combinational and are 0 during reset.
- Reset asserted mid-operation discards all in-flight tags. No response appears for reads issued before reset.
- Issue latency is 0: issue happens in the handshake cycle. Response latency: a read issued in cycle t responds in cycle t+READ_LATENCY.
- Throughput is one read per cycle. Back-to-back issues give back-to-back responses in issue order.
- Simultaneous handshake and kill of a different index: both take effect. Same index: the request is not granted.
- Pointer wrap: after granting NUM_REQ-1, priority restarts at 0.

## Structure
- Package `vrf_read_sched_pkg` holds:
  - the `read_tag_t` struct {valid, source, instructionIndex}.
  - width constants for VS, offset, index and data.
  - a `rr_next` helper function.
- Sub-module `vrf_read_sched_rr_arbiter` holds the parameterised round-robin grant logic and the `last` register. The top level instantiates it and owns the tag pipeline and kill logic.

## Test plan
- Reset, then all 4 requesters valid continuously → grants 0,1,2,3,0 on consecutive cycles. Each response returns 2 cycles after its issue with the matching `resp_source`.
- Only requester 2 valid, for 3 cycles → 3 grants to 2. Then 1 and 3 valid → 3 granted first, then 1.
- `write_busy` held high for 2 cycles with requester 1 valid → no `req_ready` and no `vrf_read_valid`. Grant to 1 in the cycle after `write_busy` drops.
- Issue reads from instructions 5 and 6 in cycles t and t+1; `kill_valid` with index 5 at t+1 → only the response for instruction 6 appears, at t+3.
- `kill_valid` with index 3 while requester 0 (instruction 3) and requester 1 (instruction 4) are valid → requester 1 granted, requester 0 not ready.
- Assert reset for 1 cycle with 2 reads in flight → no `resp_valid` afterwards. Next grant goes to requester 0.
